// File: rtl/door_idol_hit_detector_if.sv
// Pixel-stream bundle between the bitmap drawing path and the door/idol hit detector.
// HIT_DEBUG_EN adds the debug observation signals.
interface door_idol_hit_detector_if #(
    parameter int CNT_W = 11
);
    logic startOfFrame;
    logic playerDR;
    logic doorIdolDR;
    logic select;
    logic doorUnlocked;
    logic mode_sel;
    logic levelRestart;
    logic doorReached;
    logic idolCollected;
    logic idolTaken;
`ifdef HIT_DEBUG_EN
    logic [CNT_W-1:0] lastOverlapCount;
    logic [3:0]       holdCount;
`endif

    modport master (
        output startOfFrame, playerDR, doorIdolDR, select, doorUnlocked, mode_sel, levelRestart,
`ifdef HIT_DEBUG_EN
        input  lastOverlapCount, holdCount,
`endif
        input  doorReached, idolCollected, idolTaken
    );

    modport slave (
        input  startOfFrame, playerDR, doorIdolDR, select, doorUnlocked, mode_sel, levelRestart,
`ifdef HIT_DEBUG_EN
        output lastOverlapCount, holdCount,
`endif
        output doorReached, idolCollected, idolTaken
    );
endinterface

// File: rtl/door_idol_hit_detector.sv
// Door/idol hit detector: per-frame overlap count, multi-frame hold, lockout, sticky idol flag.
// Optional macro HIT_DEBUG_EN exposes lastOverlapCount and holdCount.
//
// state   | meaning
// IDLE    | target disabled (mode_sel, door locked, or idol already taken)
// ARMED   | counting consecutive hit frames
// FIRE    | one-cycle event pulse
// LOCKOUT | ignoring overlap for LOCKOUT_FRAMES frames
module door_idol_hit_detector #(
    parameter int MIN_OVERLAP_PIXELS = 16,
    parameter int HOLD_FRAMES        = 2,
    parameter int LOCKOUT_FRAMES     = 30,
    parameter int CNT_W              = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    door_idol_hit_detector_if.slave  hit_if
);
    typedef enum logic [1:0] {IDLE, ARMED, FIRE, LOCKOUT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       hold_q, hold_d;
    logic [7:0]       lock_q, lock_d;
    logic             sel_q, sel_d;
    logic             unl_q, unl_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] last_q, last_d;

    logic sof, overlap, frame_hit, target_en, fire_ok;
    logic [3:0] hold_inc;
    logic [7:0] lock_inc;

    assign sof       = hit_if.startOfFrame;
    assign overlap   = hit_if.playerDR & hit_if.doorIdolDR;
    assign frame_hit = (count_q >= CNT_W'(MIN_OVERLAP_PIXELS));
    assign hold_inc  = hold_q + 4'd1;
    assign lock_inc  = lock_q + 8'd1;
    assign sel_d     = sof ? hit_if.select : sel_q;
    assign unl_d     = sof ? hit_if.doorUnlocked : unl_q;
    assign last_d    = sof ? count_q : last_q;

    // The SOF that samples a newly enabling target already counts as enabled
    assign target_en = !hit_if.mode_sel && ((!sel_d && unl_d) || (sel_d && !taken_q));

    // A restart or mode change landing on the FIRE cycle swallows the pulse
    assign fire_ok = (state_q == FIRE) && !reset && !hit_if.levelRestart && !hit_if.mode_sel;

    assign hit_if.doorReached   = fire_ok && !sel_q;
    assign hit_if.idolCollected = fire_ok && sel_q;
    assign hit_if.idolTaken     = taken_q;

`ifdef HIT_DEBUG_EN
    assign hit_if.lastOverlapCount = last_q;
    assign hit_if.holdCount        = hold_q;
`endif

    always_comb begin
        count_d = count_q;
        if (hit_if.mode_sel) begin
            count_d = '0;
        end else if (sof) begin
            count_d = {{(CNT_W-1){1'b0}}, overlap};
        end else if (overlap && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        lock_d  = lock_q;
        taken_d = taken_q;
        if (fire_ok && sel_q) begin
            taken_d = 1'b1;
        end
        if (!target_en) begin
            state_d = IDLE;
            hold_d  = '0;
            lock_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sof) begin
                        state_d = ARMED;
                        hold_d  = '0;
                    end
                end
                ARMED: begin
                    if (sof) begin
                        if (frame_hit) begin
                            hold_d = hold_inc;
                            if (hold_inc == 4'(HOLD_FRAMES)) begin
                                state_d = FIRE;
                            end
                        end else begin
                            hold_d = '0;
                        end
                    end
                end
                FIRE: begin
                    state_d = LOCKOUT;
                    lock_d  = '0;
                end
                LOCKOUT: begin
                    if (sof) begin
                        lock_d = lock_inc;
                        if (lock_inc == 8'(LOCKOUT_FRAMES)) begin
                            state_d = ARMED;
                            hold_d  = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || hit_if.levelRestart) begin
            state_q <= ARMED;
            count_q <= '0;
            hold_q  <= '0;
            lock_q  <= '0;
            sel_q   <= 1'b0;
            unl_q   <= 1'b0;
            taken_q <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            lock_q  <= lock_d;
            sel_q   <= sel_d;
            unl_q   <= unl_d;
            taken_q <= taken_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: doc/door_idol_hit_detector.md
Name: door_idol_hit_detector

Overview:
- Consumer end of the door/idol bitmap drawing path: takes the door/idol drawingRequest and the player drawingRequest pixel by pixel and decides when the player has actually reached the door or collected the idol.
- Counts overlapping pixels per frame and requires a minimum overlap for several consecutive frames before firing.
- Emits one-cycle event pulses plus a sticky idol-taken flag, which feeds back as the bitmap's select/visibility.
- Sits between the object bitmaps and the game-state controller.

Parameters:
- MIN_OVERLAP_PIXELS, 16: overlapping pixels needed in one frame for that frame to count as a hit frame.
- HOLD_FRAMES, 2: consecutive hit frames required to fire (legal 1..15).
- LOCKOUT_FRAMES, 30: frames ignored after a fire (legal 1..255).
- CNT_W, 11: width of the per-frame overlap counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at frame start
- playerDR  in  1  player bitmap drawingRequest for the current pixel
- doorIdolDR  in  1  door/idol bitmap drawingRequest for the current pixel
- select  in  1  0 = door shown, 1 = idol shown
- doorUnlocked  in  1  door accepts entry
- mode_sel  in  1  1 = VS mode, detector disabled
- levelRestart  in  1  one-cycle pulse clearing all state including the sticky flag
- doorReached  out  1  one-cycle event pulse
- idolCollected  out  1  one-cycle event pulse
- idolTaken  out  1  sticky level

Behaviour:
- Reset: synchronous, active-high; one clock, all logic on posedge clk.
- Reset values: all outputs 0, counters 0, state ARMED.
- overlap = playerDR & doorIdolDR.
- Overlap counter:
  - Non-SOF cycles: increment when overlap; saturate at 2^CNT_W-1.
  - On startOfFrame: evaluate frameHit = (count >= MIN_OVERLAP_PIXELS), then load counter with overlap?1:0, so the SOF pixel belongs to the new frame.
- Target latch: select and doorUnlocked are sampled into registers on startOfFrame. Mid-frame changes take effect next frame.
- Target enabled when mode_sel=0 and either:
  - latched select=0 and latched doorUnlocked=1, or
  - latched select=1 and idolTaken=0.
- FSM states: IDLE, ARMED, FIRE, LOCKOUT.
- IDLE: entered in any cycle where the target is disabled. Hold count and lockout count are cleared. Leave to ARMED on the first SOF where the target is enabled.
- ARMED, on each SOF:
  - frameHit=1: holdCnt+1. If the result equals HOLD_FRAMES, go to FIRE.
  - frameHit=0: holdCnt=0.
- FIRE (one cycle):
  - Pulse doorReached if the latched target is door, or idolCollected (and set idolTaken) if idol.
  - Then go to LOCKOUT with lockCnt=0.
  - Pulse latency: asserted exactly 1 cycle after the qualifying SOF, width 1 cycle.
- LOCKOUT: lockCnt+1 on each SOF. On the SOF where it reaches LOCKOUT_FRAMES, go to ARMED with holdCnt=0. Overlap is ignored throughout.
- mode_sel=1: forces IDLE next cycle and clears the overlap counter; no pulses. idolTaken is retained.
- levelRestart: same effect as reset, including clearing idolTaken.
- Priority: reset > levelRestart > mode_sel > SOF evaluation.
- Reset or levelRestart arriving in FIRE suppresses that pulse.
- Exactly one of doorReached/idolCollected can pulse per fire; never both.
- A missing SOF does not clear counters; the counter saturates instead of wrapping.

Optional Feature:
- Macro: HIT_DEBUG_EN.
- Defined: adds output lastOverlapCount [CNT_W-1:0], which holds the counter value captured at each SOF (reset 0), and output holdCount [3:0] mirroring holdCnt.
- Not defined: these ports are absent and the behaviour is otherwise identical.

Test Plan:
- Idol hit: select=1, mode_sel=0, 20 overlap pixels in each of frames 1 and 2 → idolCollected pulses 1 cycle after SOF of frame 3; idolTaken=1 from then on; further overlaps produce no pulse.
- Frame threshold: 15 overlap pixels per frame, 10 frames → no pulse. 16 pixels in 2 frames → pulse.
- Door lock: select=0, doorUnlocked=0, 100 overlaps per frame → no pulse. Set doorUnlocked=1 → doorReached fires 1 cycle after the 2nd qualifying SOF after the first SOF sampling doorUnlocked=1.
- Lockout: door fires, overlap continues every frame → next doorReached exactly 32 SOFs after the first (30 lockout + 2 hold).
- Hold reset: hit frame, miss frame, hit frame → no pulse. A second consecutive hit then fires.
- Disable paths:
  - mode_sel=1 during hold count → no pulse; idolTaken unchanged.
  - levelRestart coinciding with FIRE → pulse suppressed, idolTaken=0, state ARMED.
  - reset mid-frame → all outputs 0 next cycle.
